// File: rtl/pll_reconfig_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : pll_reconfig_pkg
//  Description : Shared register map and FSM encoding for the PLL reconfig
//                sequencer. The optional fractional-K state is present only
//                when PLL_RECONFIG_FRAC_EN is defined.
//  Revision    : 1.0  initial release
// ============================================================================
package pll_reconfig_pkg;

    // Reconfig IP register addresses
    localparam logic [5:0] c_ADDR_MODE  = 6'h00;
    localparam logic [5:0] c_ADDR_START = 6'h02;
    localparam logic [5:0] c_ADDR_N     = 6'h03;
    localparam logic [5:0] c_ADDR_M     = 6'h04;
    localparam logic [5:0] c_ADDR_C     = 6'h05;
    localparam logic [5:0] c_ADDR_K     = 6'h07;

    // Mode register value selecting waitrequest mode; START trigger value
    localparam logic [31:0] c_MODE_WAITREQ = 32'd0;
    localparam logic [31:0] c_START_GO     = 32'd1;

    typedef enum logic [3:0] {
        S_IDLE      = 4'd0,
        S_W_MODE    = 4'd1,
        S_W_N       = 4'd2,
        S_W_M       = 4'd3,
        S_W_C       = 4'd4,
`ifdef PLL_RECONFIG_FRAC_EN
        S_W_K       = 4'd5,
`endif
        S_W_START   = 4'd6,
        S_WAIT_LOCK = 4'd7,
        S_PLL_RST   = 4'd8,
        S_DONE      = 4'd9
    } state_t;

endpackage
`default_nettype wire

// File: rtl/pll_lock_mon.sv
`default_nettype none
// ============================================================================
//  Module      : pll_lock_mon
//  Description : Synchronises the asynchronous PLL lock flag and measures how
//                long it has been continuously high, plus a timeout counter
//                that runs from the moment clr is released.
//  Revision    : 1.0  initial release
// ============================================================================
module pll_lock_mon #(
    parameter int LOCK_STABLE  = 1024,
    parameter int LOCK_TIMEOUT = 1048576
) (
    input  logic clk,
    input  logic rst,
    input  logic pll_locked,
    input  logic clr,
    output logic lock_ok,
    output logic lock_timeout
);

    localparam int c_STB_W = $clog2(LOCK_STABLE) + 1;
    localparam int c_TO_W  = $clog2(LOCK_TIMEOUT) + 1;
    localparam logic [c_STB_W-1:0] c_STB_MAX = c_STB_W'(LOCK_STABLE);
    localparam logic [c_TO_W-1:0]  c_TO_MAX  = c_TO_W'(LOCK_TIMEOUT);
    localparam logic [c_STB_W-1:0] c_STB_ONE = c_STB_W'(1);
    localparam logic [c_TO_W-1:0]  c_TO_ONE  = c_TO_W'(1);

    logic               r_sync1;
    logic               r_sync2;
    logic [c_STB_W-1:0] r_stable_cnt;
    logic [c_TO_W-1:0]  r_to_cnt;

    // Two-flop synchroniser for the asynchronous lock flag
    always_ff @(posedge clk) begin
        if (rst) begin
            r_sync1 <= 1'b0;
            r_sync2 <= 1'b0;
        end else begin
            r_sync1 <= pll_locked;
            r_sync2 <= r_sync1;
        end
    end

    // Continuous-lock counter: any low sample restarts the measurement
    always_ff @(posedge clk) begin
        if (rst || clr) begin
            r_stable_cnt <= '0;
        end else if (!r_sync2) begin
            r_stable_cnt <= '0;
        end else if (r_stable_cnt != c_STB_MAX) begin
            r_stable_cnt <= r_stable_cnt + c_STB_ONE;
        end
    end

    // Timeout counter, saturating at the limit so the flag stays asserted
    always_ff @(posedge clk) begin
        if (rst || clr) begin
            r_to_cnt <= '0;
        end else if (r_to_cnt != c_TO_MAX) begin
            r_to_cnt <= r_to_cnt + c_TO_ONE;
        end
    end

    assign lock_ok      = (r_stable_cnt == c_STB_MAX);
    assign lock_timeout = (r_to_cnt == c_TO_MAX);

endmodule
`default_nettype wire

// File: rtl/pll_reconfig_seq.sv
`default_nettype none
// ============================================================================
//  Module      : pll_reconfig_seq
//  Description : Drives a PLL frequency change through the reconfig IP
//                Avalon-MM management port (MODE, N, M, C, [K], START), then
//                waits for a stable relock, retrying via PLL reset on timeout.
//                Define PLL_RECONFIG_FRAC_EN to add the fractional-K write.
//  Revision    : 1.0  initial release
// ============================================================================
module pll_reconfig_seq
    import pll_reconfig_pkg::*;
#(
    parameter int LOCK_STABLE  = 1024,
    parameter int LOCK_TIMEOUT = 1048576,
    parameter int RST_CYCLES   = 16,
    parameter int MAX_RETRY    = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req,
    input  logic [17:0] cfg_n,
    input  logic [17:0] cfg_m,
    input  logic [17:0] cfg_c,
    input  logic [4:0]  cfg_c_sel,
    input  logic [31:0] cfg_k,
    output logic        busy,
    output logic        done,
    output logic        err,
    input  logic        pll_locked,
    output logic        pll_rst,
    output logic [5:0]  mgmt_address,
    output logic        mgmt_write,
    output logic [31:0] mgmt_writedata,
    input  logic        mgmt_waitrequest
);

    localparam int c_RST_W   = (RST_CYCLES > 1) ? $clog2(RST_CYCLES) : 1;
    localparam int c_RETRY_W = (MAX_RETRY > 0) ? $clog2(MAX_RETRY + 1) : 1;
    localparam logic [c_RST_W-1:0]   c_RST_LAST  = c_RST_W'(RST_CYCLES - 1);
    localparam logic [c_RST_W-1:0]   c_RST_ONE   = c_RST_W'(1);
    localparam logic [c_RETRY_W-1:0] c_MAX_RETRY = c_RETRY_W'(MAX_RETRY);
    localparam logic [c_RETRY_W-1:0] c_RETRY_ONE = c_RETRY_W'(1);

    state_t               r_state;
    state_t               w_state_next;
    logic [17:0]          r_cfg_n;
    logic [17:0]          r_cfg_m;
    logic [17:0]          r_cfg_c;
    logic [4:0]           r_cfg_c_sel;
    logic                 r_err;
    logic [c_RETRY_W-1:0] r_retry;
    logic [c_RST_W-1:0]   r_rst_cnt;
    logic                 w_accept;
    logic                 w_fail;
    logic                 w_rst_last;
    logic                 w_mon_clr;
    logic                 w_lock_ok;
    logic                 w_lock_timeout;

`ifdef PLL_RECONFIG_FRAC_EN
    logic [31:0]          r_cfg_k;
`else
    logic                 w_cfg_k_unused;
    assign w_cfg_k_unused = ^cfg_k;
`endif

    assign w_accept   = (r_state == S_IDLE) && req;
    assign w_rst_last = (r_rst_cnt == c_RST_LAST);
    // Lock counters only run while waiting, so each entry starts from zero
    assign w_mon_clr  = (r_state != S_WAIT_LOCK);
    assign err        = r_err;

    pll_lock_mon #(
        .LOCK_STABLE  (LOCK_STABLE),
        .LOCK_TIMEOUT (LOCK_TIMEOUT)
    ) u_lock_mon (
        .clk          (clk),
        .rst          (rst),
        .pll_locked   (pll_locked),
        .clr          (w_mon_clr),
        .lock_ok      (w_lock_ok),
        .lock_timeout (w_lock_timeout)
    );

    // FSM state register
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next-state decode and Moore outputs; success beats timeout in WAIT_LOCK
    always_comb begin
        w_state_next   = r_state;
        w_fail         = 1'b0;
        busy           = 1'b1;
        done           = 1'b0;
        pll_rst        = 1'b0;
        mgmt_write     = 1'b0;
        mgmt_address   = '0;
        mgmt_writedata = '0;
        case (r_state)
            S_IDLE: begin
                busy = 1'b0;
                if (req) begin
                    w_state_next = S_W_MODE;
                end
            end
            S_W_MODE: begin
                mgmt_write     = 1'b1;
                mgmt_address   = c_ADDR_MODE;
                mgmt_writedata = c_MODE_WAITREQ;
                if (!mgmt_waitrequest) begin
                    w_state_next = S_W_N;
                end
            end
            S_W_N: begin
                mgmt_write     = 1'b1;
                mgmt_address   = c_ADDR_N;
                mgmt_writedata = {14'b0, r_cfg_n};
                if (!mgmt_waitrequest) begin
                    w_state_next = S_W_M;
                end
            end
            S_W_M: begin
                mgmt_write     = 1'b1;
                mgmt_address   = c_ADDR_M;
                mgmt_writedata = {14'b0, r_cfg_m};
                if (!mgmt_waitrequest) begin
                    w_state_next = S_W_C;
                end
            end
            S_W_C: begin
                mgmt_write     = 1'b1;
                mgmt_address   = c_ADDR_C;
                mgmt_writedata = {9'b0, r_cfg_c_sel, r_cfg_c};
                if (!mgmt_waitrequest) begin
`ifdef PLL_RECONFIG_FRAC_EN
                    w_state_next = S_W_K;
`else
                    w_state_next = S_W_START;
`endif
                end
            end
`ifdef PLL_RECONFIG_FRAC_EN
            S_W_K: begin
                mgmt_write     = 1'b1;
                mgmt_address   = c_ADDR_K;
                mgmt_writedata = r_cfg_k;
                if (!mgmt_waitrequest) begin
                    w_state_next = S_W_START;
                end
            end
`endif
            S_W_START: begin
                mgmt_write     = 1'b1;
                mgmt_address   = c_ADDR_START;
                mgmt_writedata = c_START_GO;
                if (!mgmt_waitrequest) begin
                    w_state_next = S_WAIT_LOCK;
                end
            end
            S_WAIT_LOCK: begin
                if (w_lock_ok) begin
                    w_state_next = S_DONE;
                end else if (w_lock_timeout) begin
                    if (r_retry < c_MAX_RETRY) begin
                        w_state_next = S_PLL_RST;
                    end else begin
                        w_state_next = S_DONE;
                        w_fail       = 1'b1;
                    end
                end
            end
            S_PLL_RST: begin
                pll_rst = 1'b1;
                if (w_rst_last) begin
                    w_state_next = S_WAIT_LOCK;
                end
            end
            S_DONE: begin
                busy         = 1'b0;
                done         = 1'b1;
                w_state_next = S_IDLE;
            end
            default: begin
                busy         = 1'b0;
                w_state_next = S_IDLE;
            end
        endcase
    end

    // Capture the requested configuration when a request is accepted
    always_ff @(posedge clk) begin
        if (rst) begin
            r_cfg_n     <= '0;
            r_cfg_m     <= '0;
            r_cfg_c     <= '0;
            r_cfg_c_sel <= '0;
        end else if (w_accept) begin
            r_cfg_n     <= cfg_n;
            r_cfg_m     <= cfg_m;
            r_cfg_c     <= cfg_c;
            r_cfg_c_sel <= cfg_c_sel;
        end
    end

`ifdef PLL_RECONFIG_FRAC_EN
    // Fractional K latch, only needed for fractional-VCO PLLs
    always_ff @(posedge clk) begin
        if (rst) begin
            r_cfg_k <= '0;
        end else if (w_accept) begin
            r_cfg_k <= cfg_k;
        end
    end
`endif

    // Error flag: cleared on a new request, set when the final attempt times out
    always_ff @(posedge clk) begin
        if (rst || w_accept) begin
            r_err <= 1'b0;
        end else if (w_fail) begin
            r_err <= 1'b1;
        end
    end

    // Retry count, bumped as each PLL reset pulse completes
    always_ff @(posedge clk) begin
        if (rst || w_accept) begin
            r_retry <= '0;
        end else if ((r_state == S_PLL_RST) && w_rst_last) begin
            r_retry <= r_retry + c_RETRY_ONE;
        end
    end

    // PLL reset pulse length counter
    always_ff @(posedge clk) begin
        if (rst || (r_state != S_PLL_RST)) begin
            r_rst_cnt <= '0;
        end else begin
            r_rst_cnt <= r_rst_cnt + c_RST_ONE;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_pll_reconfig_seq.sv
`default_nettype none
// ============================================================================
//  Module      : tb_pll_reconfig_seq
//  Description : Self-checking bench for pll_reconfig_seq. Expected management
//                writes are queued when a request is driven and popped as the
//                DUT completes each write. Honours PLL_RECONFIG_FRAC_EN.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_pll_reconfig_seq;

    localparam int LOCK_STABLE  = 16;
    localparam int LOCK_TIMEOUT = 64;
    localparam int RST_CYCLES   = 16;
    localparam int MAX_RETRY    = 1;
`ifdef PLL_RECONFIG_FRAC_EN
    localparam int N_WR = 6;
`else
    localparam int N_WR = 5;
`endif
    // Done arrives two sync stages, LOCK_STABLE counts and one state hop after lock rises
    localparam int DONE_MIN = LOCK_STABLE + 1;
    localparam int DONE_MAX = LOCK_STABLE + 5;

    logic        clk = 1'b0;
    logic        rst, req, pll_locked;
    logic [17:0] cfg_n, cfg_m, cfg_c;
    logic [4:0]  cfg_c_sel;
    logic [31:0] cfg_k;
    logic        busy, done, err, pll_rst, mgmt_write;
    logic [5:0]  mgmt_address;
    logic [31:0] mgmt_writedata;
    logic        mgmt_waitrequest = 1'b0;

    typedef struct packed {
        logic [5:0]  addr;
        logic [31:0] data;
    } wr_t;

    wr_t         exp_q[$];
    int          total = 0;
    int          bad = 0;
    int          n_writes = 0;
    int          stall_cfg = 0;
    int          stall_left = 0;
    bit          acc_now = 1'b0;
    bit          stall_valid = 1'b0;
    logic [5:0]  stall_addr;
    logic [31:0] stall_data;

    pll_reconfig_seq #(
        .LOCK_STABLE  (LOCK_STABLE),
        .LOCK_TIMEOUT (LOCK_TIMEOUT),
        .RST_CYCLES   (RST_CYCLES),
        .MAX_RETRY    (MAX_RETRY)
    ) dut (
        .clk              (clk),
        .rst              (rst),
        .req              (req),
        .cfg_n            (cfg_n),
        .cfg_m            (cfg_m),
        .cfg_c            (cfg_c),
        .cfg_c_sel        (cfg_c_sel),
        .cfg_k            (cfg_k),
        .busy             (busy),
        .done             (done),
        .err              (err),
        .pll_locked       (pll_locked),
        .pll_rst          (pll_rst),
        .mgmt_address     (mgmt_address),
        .mgmt_write       (mgmt_write),
        .mgmt_writedata   (mgmt_writedata),
        .mgmt_waitrequest (mgmt_waitrequest)
    );

    always #5 clk = ~clk;

    // Slave model: each new write is stalled for stall_cfg cycles
    always @(negedge clk) acc_now = mgmt_write && !mgmt_waitrequest;
    always @(posedge clk) begin
        #1;
        if (rst || !mgmt_write || acc_now) stall_left = stall_cfg;
        if (mgmt_write && !rst && stall_left > 0) begin
            mgmt_waitrequest = 1'b1;
            stall_left--;
        end else begin
            mgmt_waitrequest = 1'b0;
        end
    end

    // Write monitor: stall stability and in-order scoreboard
    always @(negedge clk) begin
        if (!rst && mgmt_write) begin
            if (stall_valid) begin
                total++;
                if (mgmt_address !== stall_addr || mgmt_writedata !== stall_data) begin
                    bad++;
                    $display("FAIL stall_stable got addr=%h data=%h required addr=%h data=%h",
                             mgmt_address, mgmt_writedata, stall_addr, stall_data);
                end
            end
            if (mgmt_waitrequest) begin
                stall_valid = 1'b1;
                stall_addr  = mgmt_address;
                stall_data  = mgmt_writedata;
            end else begin
                wr_t e;
                stall_valid = 1'b0;
                n_writes++;
                total++;
                if (exp_q.size() == 0) begin
                    bad++;
                    $display("FAIL write_unexpected got addr=%h data=%h required none",
                             mgmt_address, mgmt_writedata);
                end else begin
                    e = exp_q.pop_front();
                    if (mgmt_address !== e.addr || mgmt_writedata !== e.data) begin
                        bad++;
                        $display("FAIL write_order got addr=%h data=%h required addr=%h data=%h",
                                 mgmt_address, mgmt_writedata, e.addr, e.data);
                    end
                end
            end
        end else begin
            stall_valid = 1'b0;
        end
    end

    task automatic issue_req(input logic [17:0] n, input logic [17:0] m, input logic [17:0] c,
                             input logic [4:0] sel, input logic [31:0] k);
        @(posedge clk); #1;
        cfg_n = n; cfg_m = m; cfg_c = c; cfg_c_sel = sel; cfg_k = k;
        req = 1'b1;
        exp_q.push_back(wr_t'{6'h00, 32'd0});
        exp_q.push_back(wr_t'{6'h03, {14'b0, n}});
        exp_q.push_back(wr_t'{6'h04, {14'b0, m}});
        exp_q.push_back(wr_t'{6'h05, {9'b0, sel, c}});
`ifdef PLL_RECONFIG_FRAC_EN
        exp_q.push_back(wr_t'{6'h07, k});
`endif
        exp_q.push_back(wr_t'{6'h02, 32'd1});
        @(posedge clk); #1;
        req = 1'b0;
    endtask

    task automatic wait_writes(input int budget, input string tag);
        for (int i = 0; i < budget && exp_q.size() != 0; i++) @(posedge clk);
        total++;
        if (exp_q.size() != 0) begin
            bad++;
            $display("FAIL %s_writes outstanding=%0d required=0", tag, exp_q.size());
            exp_q.delete();
        end
        #1;
    endtask

    task automatic wait_done(input int budget, output int cyc, output bit got);
        got = 1'b0;
        cyc = 0;
        while (!got && cyc < budget) begin
            @(negedge clk);
            cyc++;
            if (done === 1'b1) got = 1'b1;
        end
    endtask

    task automatic test_reset();
        rst = 1'b1; req = 1'b0; pll_locked = 1'b0;
        cfg_n = '0; cfg_m = '0; cfg_c = '0; cfg_c_sel = '0; cfg_k = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        total++;
        if ({busy, done, err, pll_rst, mgmt_write} !== 5'b0) begin
            bad++;
            $display("FAIL reset_flags got=%b required=00000", {busy, done, err, pll_rst, mgmt_write});
        end
        total++;
        if (mgmt_address !== 6'h0 || mgmt_writedata !== 32'h0) begin
            bad++;
            $display("FAIL reset_bus got addr=%h data=%h required 0", mgmt_address, mgmt_writedata);
        end
        @(posedge clk); #1;
        rst = 1'b0;
    endtask

    task automatic run_lock_ok(input int stall, input string tag);
        int  cyc;
        bit  got;
        int  w0;
        stall_cfg  = stall;
        pll_locked = 1'b0;
        w0 = n_writes;
        issue_req(18'h00808, 18'h01414, 18'h00404, 5'd2, 32'h1234_5678);
        @(negedge clk);
        total++;
        if (busy !== 1'b1) begin
            bad++;
            $display("FAIL %s_busy got=%b required=1", tag, busy);
        end
        wait_writes(200, tag);
        repeat (9) @(posedge clk);
        #1 pll_locked = 1'b1;
        wait_done(200, cyc, got);
        total++;
        if (!got || cyc < DONE_MIN || cyc > DONE_MAX) begin
            bad++;
            $display("FAIL %s_done_latency got=%0d seen=%0d required=%0d..%0d", tag, cyc, got, DONE_MIN, DONE_MAX);
        end
        total++;
        if (err !== 1'b0 || busy !== 1'b0) begin
            bad++;
            $display("FAIL %s_done_status got err=%b busy=%b required err=0 busy=0", tag, err, busy);
        end
        total++;
        if (n_writes - w0 != N_WR) begin
            bad++;
            $display("FAIL %s_write_count got=%0d required=%0d", tag, n_writes - w0, N_WR);
        end
        @(posedge clk); #1 pll_locked = 1'b0;
        @(negedge clk);
        total++;
        if (done !== 1'b0 || busy !== 1'b0) begin
            bad++;
            $display("FAIL %s_idle_after got done=%b busy=%b required 0 0", tag, done, busy);
        end
    endtask

    task automatic test_basic();
        run_lock_ok(0, "basic");
    endtask

    task automatic test_waitrequest();
        run_lock_ok(3, "stall");
    endtask

    task automatic test_lock_glitch();
        int cyc;
        bit got;
        stall_cfg = 0;
        pll_locked = 1'b0;
        issue_req(18'h00202, 18'h00a0a, 18'h00101, 5'd17, 32'hcafe_0001);
        wait_writes(100, "glitch");
        repeat (4) @(posedge clk);
        #1 pll_locked = 1'b1;
        repeat (8) @(posedge clk);
        #1 pll_locked = 1'b0;
        repeat (2) @(posedge clk);
        #1 pll_locked = 1'b1;
        wait_done(200, cyc, got);
        total++;
        if (!got || cyc < DONE_MIN || cyc > DONE_MAX) begin
            bad++;
            $display("FAIL glitch_done_latency got=%0d seen=%0d required=%0d..%0d", cyc, got, DONE_MIN, DONE_MAX);
        end
        total++;
        if (err !== 1'b0) begin
            bad++;
            $display("FAIL glitch_err got=%b required=0", err);
        end
        @(posedge clk); #1 pll_locked = 1'b0;
    endtask

    task automatic test_timeout();
        int  cyc = 0;
        bit  got = 1'b0;
        int  rst_hi = 0;
        int  pulses = 0;
        bit  prev = 1'b0;
        stall_cfg = 0;
        pll_locked = 1'b0;
        issue_req(18'h00303, 18'h00505, 18'h00707, 5'd0, 32'h0);
        wait_writes(100, "timeout");
        while (!got && cyc < 600) begin
            @(negedge clk);
            cyc++;
            if (pll_rst === 1'b1) rst_hi++;
            if (pll_rst === 1'b1 && !prev) pulses++;
            prev = (pll_rst === 1'b1);
            if (done === 1'b1) got = 1'b1;
        end
        total++;
        if (!got) begin
            bad++;
            $display("FAIL timeout_done got=0 required=1");
        end
        total++;
        if (rst_hi != RST_CYCLES || pulses != 1) begin
            bad++;
            $display("FAIL timeout_pll_rst got cycles=%0d pulses=%0d required cycles=%0d pulses=1",
                     rst_hi, pulses, RST_CYCLES);
        end
        total++;
        if (err !== 1'b1 || busy !== 1'b0) begin
            bad++;
            $display("FAIL timeout_status got err=%b busy=%b required err=1 busy=0", err, busy);
        end
        repeat (2) @(negedge clk);
        total++;
        if (err !== 1'b1 || done !== 1'b0) begin
            bad++;
            $display("FAIL timeout_err_hold got err=%b done=%b required err=1 done=0", err, done);
        end
    endtask

    task automatic test_back_to_back();
        int cyc;
        bit got;
        bit busy_seen = 1'b0;
        int w0;
        stall_cfg = 1;
        pll_locked = 1'b0;
        w0 = n_writes;
        issue_req(18'h10001, 18'h20002, 18'h30003, 5'd9, 32'h0bad_f00d);
        @(negedge clk);
        total++;
        if (err !== 1'b0) begin
            bad++;
            $display("FAIL b2b_err_clear got=%b required=0", err);
        end
        // Extra requests with different configuration while busy
        @(posedge clk); #1;
        cfg_n = 18'h3ffff; cfg_m = 18'h3ffff; cfg_c = 18'h3ffff; cfg_c_sel = 5'd31; cfg_k = '1;
        req = 1'b1;
        @(posedge clk); #1 req = 1'b0;
        wait_writes(100, "b2b");
        @(posedge clk); #1 req = 1'b1;
        @(posedge clk); #1 req = 1'b0;
        pll_locked = 1'b1;
        wait_done(200, cyc, got);
        total++;
        if (!got) begin
            bad++;
            $display("FAIL b2b_done got=0 required=1");
        end
        req = 1'b1;
        @(posedge clk); #1 req = 1'b0;
        pll_locked = 1'b0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            if (busy === 1'b1 || mgmt_write === 1'b1) busy_seen = 1'b1;
        end
        total++;
        if (busy_seen) begin
            bad++;
            $display("FAIL b2b_done_cycle_req got busy/write=1 required=0");
        end
        total++;
        if (n_writes - w0 != N_WR) begin
            bad++;
            $display("FAIL b2b_write_count got=%0d required=%0d", n_writes - w0, N_WR);
        end
    endtask

    task automatic test_reset_mid_write();
        int  cyc = 0;
        bit  got = 1'b0;
        stall_cfg = 20;
        pll_locked = 1'b0;
        issue_req(18'h01111, 18'h02222, 18'h03333, 5'd5, 32'h5555_aaaa);
        while (!got && cyc < 100) begin
            @(negedge clk);
            cyc++;
            if (mgmt_write === 1'b1 && mgmt_address === 6'h04) got = 1'b1;
        end
        total++;
        if (!got) begin
            bad++;
            $display("FAIL rstmid_reach_m got=0 required=1");
        end
        rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        total++;
        if ({busy, done, err, pll_rst, mgmt_write} !== 5'b0 || mgmt_address !== 6'h0 || mgmt_writedata !== 32'h0) begin
            bad++;
            $display("FAIL rstmid_outputs got flags=%b addr=%h data=%h required 0",
                     {busy, done, err, pll_rst, mgmt_write}, mgmt_address, mgmt_writedata);
        end
        exp_q.delete();
        @(posedge clk); #1 rst = 1'b0;
        stall_cfg = 0;
        issue_req(18'h00a0a, 18'h00b0b, 18'h00c0c, 5'd1, 32'h0000_0042);
        wait_writes(100, "rstmid");
        pll_locked = 1'b1;
        wait_done(200, cyc, got);
        total++;
        if (!got || err !== 1'b0) begin
            bad++;
            $display("FAIL rstmid_restart got done=%b err=%b required done=1 err=0", got, err);
        end
        @(posedge clk); #1 pll_locked = 1'b0;
    endtask

    initial begin
        test_reset();
        test_basic();
        test_waitrequest();
        test_lock_glitch();
        test_timeout();
        test_back_to_back();
        test_reset_mid_write();
        repeat (4) @(posedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
